// File: rtl/prior_req_arb.sv
// Registered pending-request arbiter. Request pulses are captured into a pending
// register, and the highest-priority pending index is offered with a VALID/ACK handshake.

module prior_req_arb_lane (
   input  logic pend_q,
   input  logic req,
   input  logic clr,
   output logic pend_d,
   output logic hit
);
   // A new request wins over a clear of the same bit
   assign pend_d = (pend_q & ~clr) | req;
   assign hit    = req & pend_q & ~clr;
endmodule

module prior_req_arb #(
   parameter int N  = 8,
   parameter int AW = $clog2(N),
   parameter int RR = 0,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  i,
   input  logic          ack,
   output logic [N-1:0]  pend,
   output logic [AW-1:0] a,
   output logic          valid,
   output logic          idle,
   output logic          ovf,
   output logic [CW-1:0] cnt
);
   typedef struct packed {
      logic          vld;
      logic [AW-1:0] idx;
   } grant_t;

   localparam logic [AW-1:0] PTR_TOP = AW'(N - 1);

   logic [AW-1:0] ptr;
   grant_t        gnt;
   logic [AW-1:0] idx;
   logic          fire;
   logic [N-1:0]  clr_mask;
   logic [N-1:0]  pend_d;
   logic [N-1:0]  hit;

   // Circular search downward from ptr; first pending bit wins
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) >= k) ? AW'(int'(ptr) - k) : AW'(int'(ptr) + N - k);
         if (!gnt.vld && pend[idx]) begin
            gnt.vld = 1'b1;
            gnt.idx = idx;
         end
      end
   end

   assign a     = gnt.idx;
   assign valid = gnt.vld;
   assign idle  = ~gnt.vld;
   assign fire  = gnt.vld & ack;

   always_comb begin
      clr_mask = '0;
      if (fire) clr_mask[gnt.idx] = 1'b1;
   end

   prior_req_arb_lane u_lane [N-1:0] (
      .pend_q (pend),
      .req    (i),
      .clr    (clr_mask),
      .pend_d (pend_d),
      .hit    (hit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
         ptr  <= PTR_TOP;
         ovf  <= 1'b0;
         cnt  <= '0;
      end else begin
         pend <= pend_d;
         ovf  <= |hit;
         cnt  <= cnt + CW'(fire);
         // Round-robin: the granted source drops to lowest priority
         if (RR != 0 && fire)
            ptr <= (gnt.idx == '0) ? PTR_TOP : gnt.idx - 1'b1;
      end
   end
endmodule
